wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Writeback pipeline stage: the last register stage before the 8x16 register file.
- Accepts one retiring instruction per cycle from the memory stage, along with its ALU/immediate result.
- For LD, waits for the data-memory read response.
- Drives the register file's load, wsel, d_a and d_d inputs. Also provides a forwarding tap for the hazard logic and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retire counter (wraps modulo 2^CNT_W)

Ports:
CLK  input  1  clock, rising edge
RSTN  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents a retiring instruction
in_ready  output  1  stage can accept this cycle
in_inst  input  16  instruction word
in_alu  input  16  ALU/LI/MUL result for the instruction
mem_rvalid  input  1  data-memory read data valid (one-cycle pulse)
mem_rdata  input  16  data-memory read data
load  output  1  regfile write strobe (one-cycle pulse)
wsel  output  16  instruction word presented to regfile
d_a  output  16  arithmetic result to regfile
d_d  output  16  load data to regfile
fwd_valid  output  1  fwd_data is being written this cycle
fwd_reg  output  3  destination register of fwd_data
fwd_data  output  16  value being written
retire_cnt  output  CNT_W  count of completed instructions

Behaviour:
- Decode classes from bits [15:14]:
  - 10 = B/BNZ
  - 11 = BGE
  - 00 with [4:0]=00000 = ST
  - 00 with [4:0]=00001 = LD
  - any other = ALU (ADD/LI/MUL)
- Destination register is [13:11]. Writer classes are LD and ALU.
- State machine, two states:
  - IDLE: in_ready=1.
  - LDWAIT: in_ready=0.
- Accept occurs when in_valid && in_ready at a rising edge. On accept:
  - wsel <= in_inst and d_a <= in_alu.
  - ALU: load <= 1 for the next cycle. State stays IDLE.
  - B/BNZ/BGE/ST: load <= 0. Stays IDLE. Counted as completed.
  - LD: load <= 0. State -> LDWAIT. d_d is unchanged.
- In LDWAIT, on mem_rvalid:
  - d_d <= mem_rdata, load <= 1 next cycle, state -> IDLE.
  - No new accept is possible in that cycle, because in_ready=0.
- In LDWAIT without mem_rvalid: hold indefinitely; outputs stable; load=0.
- mem_rvalid in IDLE is stale and ignored; no state, data or counter change.
- load is high for exactly one cycle per writer.
  - Back-to-back ALU accepts give consecutive load pulses, each with its own wsel/d_a.
  - wsel, d_a and d_d hold their last values while load=0.
- Write latency:
  - ALU: accept edge +1 cycle load pulse. The regfile captures at the following edge.
  - LD: mem_rvalid edge +1 cycle load pulse.
- Forwarding is combinational from stage registers:
  - fwd_valid = load.
  - fwd_reg = wsel[13:11].
  - fwd_data = d_d when wsel is LD, else d_a.
- retire_cnt increments by 1 on:
  - each accept edge of a non-LD instruction;
  - each edge where mem_rvalid completes LDWAIT.
  - Wraps from all-ones to 0.
- Reset (asynchronous, any state including LDWAIT) sets:
  - state IDLE;
  - load, wsel, d_a, d_d and retire_cnt to 0;
  - in_ready=1 once RSTN deasserts.
  - A pending LD is discarded and is not counted. A mem_rvalid for it arriving after reset is ignored as stale.

Decomposition:
- Shared package holds:
  - class field constants: CLS_B=2'b10, CLS_BGE=2'b11, CLS_MEM=2'b00;
  - function codes: FN_ST=5'b00000, FN_LD=5'b00001;
  - field positions: DEST_HI=13, DEST_LO=11;
  - state encoding for IDLE/LDWAIT.
- One natural combinational sub-module, inst_class_decode. Input: 16-bit word. Outputs: is_ld, is_st, is_branch, is_writer, dest[2:0].
- The same decoder is reusable by the hazard unit.

Test Plan:
- ALU write: accept in_inst=16'h2802 (ADD r5) with in_alu=16'h1234 → next cycle load=1, wsel=16'h2802, d_a=16'h1234, fwd_valid=1, fwd_reg=5, fwd_data=16'h1234; the cycle after that load=0; retire_cnt=1.
- LD wait: accept 16'h1801 (LD r3) → in_ready=0, load=0 for 3 idle cycles; pulse mem_rvalid with mem_rdata=16'hBEEF → next cycle load=1, d_d=16'hBEEF, fwd_reg=3, fwd_data=16'hBEEF, in_ready=1; retire_cnt=1.
- Non-writers: accept 16'h8000 (B), then 16'h1000 (ST), then 16'hC000 (BGE) on consecutive cycles → load stays 0 throughout; retire_cnt=3.
- Back-to-back: ALU 16'h0802 (r1, 16'h0001) then 16'h1002 (r2, 16'h0002) → load=1 for two consecutive cycles with fwd_reg 1 then 2; stray mem_rvalid in IDLE → no change.
- Reset mid-LD: accept 16'h1801, assert RSTN=0 during LDWAIT → all outputs 0 immediately; after release, a mem_rvalid with 16'hFFFF → load stays 0, retire_cnt=0.
- Wrap: CNT_W=4, retire 16 ALU instructions → retire_cnt returns to 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: instruction field layout,
// class/function codes, FSM encoding and a reusable instruction classifier.
package wb_stage_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 3;

  localparam int unsigned CLS_HI  = 15;
  localparam int unsigned CLS_LO  = 14;
  localparam int unsigned FN_HI   = 4;
  localparam int unsigned FN_LO   = 0;
  localparam int unsigned DEST_HI = 13;
  localparam int unsigned DEST_LO = 11;

  localparam logic [1:0] CLS_B   = 2'b10;
  localparam logic [1:0] CLS_BGE = 2'b11;
  localparam logic [1:0] CLS_MEM = 2'b00;

  localparam logic [4:0] FN_ST = 5'b00000;
  localparam logic [4:0] FN_LD = 5'b00001;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LDWAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic             is_ld;
    logic             is_st;
    logic             is_branch;
    logic             is_writer;
    logic [REG_W-1:0] dest;
  } inst_class_t;

  // Classify one instruction word; ALU is everything that is not a branch or memory op.
  function automatic inst_class_t classify(input logic [INST_W-1:0] inst);
    inst_class_t c;
    logic [1:0]  cls;
    logic [4:0]  fn;
    cls         = inst[CLS_HI:CLS_LO];
    fn          = inst[FN_HI:FN_LO];
    c.is_branch = (cls == CLS_B) || (cls == CLS_BGE);
    c.is_st     = (cls == CLS_MEM) && (fn == FN_ST);
    c.is_ld     = (cls == CLS_MEM) && (fn == FN_LD);
    c.is_writer = !c.is_branch && !c.is_st;
    c.dest      = inst[DEST_HI:DEST_LO];
    return c;
  endfunction

endpackage

// File: rtl/wb_stage_inst_class_decode.sv
// Combinational instruction class decoder, shared by writeback and hazard logic.
module inst_class_decode
  import wb_stage_pkg::*;
(
  input  logic [INST_W-1:0] inst,
  output logic              is_ld,
  output logic              is_st,
  output logic              is_branch,
  output logic              is_writer,
  output logic [REG_W-1:0]  dest
);

  inst_class_t cls;

  assign cls       = classify(inst);
  assign is_ld     = cls.is_ld;
  assign is_st     = cls.is_st;
  assign is_branch = cls.is_branch;
  assign is_writer = cls.is_writer;
  assign dest      = cls.dest;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the retiring instruction, waits on load data,
// strobes the register file, exposes a forwarding tap and counts retirements.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_alu,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              load,
  output logic [INST_W-1:0] wsel,
  output logic [DATA_W-1:0] d_a,
  output logic [DATA_W-1:0] d_d,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  wb_state_e state;

  logic             in_is_ld;
  logic             in_is_st;
  logic             in_is_branch;
  logic             in_is_writer;
  logic [REG_W-1:0] in_dest;

  logic             ws_is_ld;
  logic             ws_is_st;
  logic             ws_is_branch;
  logic             ws_is_writer;
  logic [REG_W-1:0] ws_dest;

  logic             unused_dec;

  inst_class_decode u_in_dec (
    .inst      (in_inst),
    .is_ld     (in_is_ld),
    .is_st     (in_is_st),
    .is_branch (in_is_branch),
    .is_writer (in_is_writer),
    .dest      (in_dest)
  );

  // Second decoder looks at the held word so forwarding follows the stage registers.
  inst_class_decode u_ws_dec (
    .inst      (wsel),
    .is_ld     (ws_is_ld),
    .is_st     (ws_is_st),
    .is_branch (ws_is_branch),
    .is_writer (ws_is_writer),
    .dest      (ws_dest)
  );

  assign unused_dec = ^{in_is_st, in_is_branch, in_dest, ws_is_st, ws_is_branch, ws_is_writer};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= ST_IDLE;
      load       <= 1'b0;
      wsel       <= '0;
      d_a        <= '0;
      d_d        <= '0;
      retire_cnt <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            wsel <= in_inst;
            d_a  <= in_alu;
            if (in_is_ld) begin
              state <= ST_LDWAIT;
            end else begin
              load       <= in_is_writer;
              retire_cnt <= retire_cnt + CNT_W'(1);
            end
          end
        end
        ST_LDWAIT: begin
          // Load completes only here; IDLE-time read responses are stale.
          if (mem_rvalid) begin
            d_d        <= mem_rdata;
            load       <= 1'b1;
            retire_cnt <= retire_cnt + CNT_W'(1);
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign fwd_valid = load;
  assign fwd_reg   = ws_dest;
  assign fwd_data  = ws_is_ld ? d_d : d_a;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// checked against a transaction-level model of the writeback rules.
module tb_wb_stage;

  logic CLK = 1'b0;
  logic RSTN;
  logic in_valid;
  logic [15:0] in_inst;
  logic [15:0] in_alu;
  logic mem_rvalid;
  logic [15:0] mem_rdata;

  logic in_ready, load, fwd_valid;
  logic [15:0] wsel, d_a, d_d, fwd_data, retire_cnt;
  logic [2:0] fwd_reg;

  logic in_ready4, load4, fwd_valid4;
  logic [15:0] wsel4, d_a4, d_d4, fwd_data4;
  logic [2:0] fwd_reg4;
  logic [3:0] retire_cnt4;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the register file should be told, and whether a load is outstanding.
  bit          m_load;
  logic [15:0] m_wsel, m_da, m_dd;
  int unsigned m_cnt;
  bit          m_busy;

  always #5 CLK = ~CLK;

  wb_stage #(.CNT_W(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_alu(in_alu), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .load(load), .wsel(wsel), .d_a(d_a), .d_d(d_d), .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg), .fwd_data(fwd_data), .retire_cnt(retire_cnt)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready4),
    .in_inst(in_inst), .in_alu(in_alu), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .load(load4), .wsel(wsel4), .d_a(d_a4), .d_d(d_d4), .fwd_valid(fwd_valid4),
    .fwd_reg(fwd_reg4), .fwd_data(fwd_data4), .retire_cnt(retire_cnt4)
  );

  function automatic bit f_is_ld(input logic [15:0] w);
    return (w[15:14] == 2'b00) && (w[4:0] == 5'b00001);
  endfunction

  function automatic bit f_writes(input logic [15:0] w);
    if (w[15]) return 1'b0;
    if (w[15:14] == 2'b00 && w[4:0] == 5'b00000) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_load = 0; m_wsel = 0; m_da = 0; m_dd = 0; m_cnt = 0; m_busy = 0;
  endtask

  task automatic cycle(input logic v, input logic [15:0] inst, input logic [15:0] alu,
                       input logic rv, input logic [15:0] rd);
    in_valid = v; in_inst = inst; in_alu = alu; mem_rvalid = rv; mem_rdata = rd;
    @(posedge CLK);
    if (!m_busy) begin
      m_load = 0;
      if (v) begin
        m_wsel = inst;
        m_da   = alu;
        if (f_is_ld(inst)) m_busy = 1;
        else begin
          m_cnt  = m_cnt + 1;
          m_load = f_writes(inst);
        end
      end
    end else begin
      m_load = 0;
      if (rv) begin
        m_dd = rd; m_load = 1; m_busy = 0; m_cnt = m_cnt + 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; mem_rvalid = 0; in_inst = 0; in_alu = 0; mem_rdata = 0;
    RSTN = 0;
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({in_ready, load, wsel, d_a, d_d, fwd_valid, retire_cnt} !== {1'b1, 1'b0, 48'h0, 1'b0, 16'h0}) begin
      n_errors++;
      $display("FAIL reset_state: rdy=%0b load=%0b wsel=%h d_a=%h d_d=%h fv=%0b cnt=%0d, want rdy=1 rest 0",
               in_ready, load, wsel, d_a, d_d, fwd_valid, retire_cnt);
    end
    n_checks++;
    if ({in_ready4, load4, retire_cnt4} !== {1'b1, 1'b0, 4'h0}) begin
      n_errors++;
      $display("FAIL reset_state_w4: rdy=%0b load=%0b cnt=%0d, want 1 0 0", in_ready4, load4, retire_cnt4);
    end
  endtask

  task automatic test_alu_write();
    do_reset();
    cycle(1, 16'h2802, 16'h1234, 0, 0);
    n_checks++;
    if ({load, wsel, d_a, fwd_valid, fwd_reg, fwd_data, retire_cnt} !==
        {1'b1, 16'h2802, 16'h1234, 1'b1, 3'd5, 16'h1234, 16'd1}) begin
      n_errors++;
      $display("FAIL alu_write: load=%0b wsel=%h d_a=%h fv=%0b freg=%0d fdata=%h cnt=%0d, want 1 2802 1234 1 5 1234 1",
               load, wsel, d_a, fwd_valid, fwd_reg, fwd_data, retire_cnt);
    end
    cycle(0, 16'h0, 16'h0, 0, 0);
    n_checks++;
    if ({load, fwd_valid, wsel, d_a, retire_cnt} !== {2'b00, 16'h2802, 16'h1234, 16'd1}) begin
      n_errors++;
      $display("FAIL alu_pulse_end: load=%0b fv=%0b wsel=%h d_a=%h cnt=%0d, want 0 0 2802 1234 1",
               load, fwd_valid, wsel, d_a, retire_cnt);
    end
  endtask

  task automatic test_ld_wait();
    do_reset();
    cycle(1, 16'h1801, 16'h0055, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({in_ready, load, retire_cnt} !== {1'b0, 1'b0, 16'd0}) begin
        n_errors++;
        $display("FAIL ld_wait[%0d]: rdy=%0b load=%0b cnt=%0d, want 0 0 0", i, in_ready, load, retire_cnt);
      end
      cycle(0, 16'h0, 16'h0, 0, 0);
    end
    cycle(1, 16'h2802, 16'h9999, 1, 16'hBEEF);
    n_checks++;
    if ({load, d_d, fwd_reg, fwd_data, in_ready, retire_cnt, wsel} !==
        {1'b1, 16'hBEEF, 3'd3, 16'hBEEF, 1'b1, 16'd1, 16'h1801}) begin
      n_errors++;
      $display("FAIL ld_complete: load=%0b d_d=%h freg=%0d fdata=%h rdy=%0b cnt=%0d wsel=%h, want 1 beef 3 beef 1 1 1801",
               load, d_d, fwd_reg, fwd_data, in_ready, retire_cnt, wsel);
    end
    cycle(0, 16'h0, 16'h0, 0, 0);
    n_checks++;
    if ({load, d_d} !== {1'b0, 16'hBEEF}) begin
      n_errors++;
      $display("FAIL ld_pulse_end: load=%0b d_d=%h, want 0 beef", load, d_d);
    end
  endtask

  task automatic test_non_writers();
    logic [15:0] seq [3];
    seq[0] = 16'h8000; seq[1] = 16'h1000; seq[2] = 16'hC000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, seq[i], 16'hAAAA, 0, 0);
      n_checks++;
      if ({load, fwd_valid, in_ready, wsel} !== {1'b0, 1'b0, 1'b1, seq[i]}) begin
        n_errors++;
        $display("FAIL non_writer[%0d]: load=%0b fv=%0b rdy=%0b wsel=%h, want 0 0 1 %h",
                 i, load, fwd_valid, in_ready, wsel, seq[i]);
      end
    end
    cycle(0, 16'h0, 16'h0, 0, 0);
    n_checks++;
    if ({load, retire_cnt} !== {1'b0, 16'd3}) begin
      n_errors++;
      $display("FAIL non_writer_count: load=%0b cnt=%0d, want 0 3", load, retire_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1, 16'h0802, 16'h0001, 0, 0);
    n_checks++;
    if ({load, fwd_reg, fwd_data} !== {1'b1, 3'd1, 16'h0001}) begin
      n_errors++;
      $display("FAIL b2b_first: load=%0b freg=%0d fdata=%h, want 1 1 0001", load, fwd_reg, fwd_data);
    end
    cycle(1, 16'h1002, 16'h0002, 0, 0);
    n_checks++;
    if ({load, fwd_reg, fwd_data, wsel} !== {1'b1, 3'd2, 16'h0002, 16'h1002}) begin
      n_errors++;
      $display("FAIL b2b_second: load=%0b freg=%0d fdata=%h wsel=%h, want 1 2 0002 1002", load, fwd_reg, fwd_data, wsel);
    end
    cycle(0, 16'h0, 16'h0, 1, 16'h5555);
    n_checks++;
    if ({load, in_ready, d_d, d_a, wsel, retire_cnt} !== {1'b0, 1'b1, 16'h0, 16'h0002, 16'h1002, 16'd2}) begin
      n_errors++;
      $display("FAIL stale_rvalid: load=%0b rdy=%0b d_d=%h d_a=%h wsel=%h cnt=%0d, want 0 1 0000 0002 1002 2",
               load, in_ready, d_d, d_a, wsel, retire_cnt);
    end
  endtask

  task automatic test_reset_mid_ld();
    do_reset();
    cycle(1, 16'h1801, 16'h7777, 0, 0);
    cycle(0, 16'h0, 16'h0, 0, 0);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_ld_busy: rdy=%0b, want 0", in_ready);
    end
    #2 RSTN = 0;
    model_reset();
    #1;
    n_checks++;
    if ({load, wsel, d_a, d_d, retire_cnt, in_ready} !== {1'b0, 64'h0, 1'b1}) begin
      n_errors++;
      $display("FAIL mid_ld_reset: load=%0b wsel=%h d_a=%h d_d=%h cnt=%0d rdy=%0b, want 0 0 0 0 0 1",
               load, wsel, d_a, d_d, retire_cnt, in_ready);
    end
    @(negedge CLK);
    RSTN = 1;
    cycle(0, 16'h0, 16'h0, 1, 16'hFFFF);
    n_checks++;
    if ({load, d_d, retire_cnt, in_ready} !== {1'b0, 16'h0, 16'd0, 1'b1}) begin
      n_errors++;
      $display("FAIL mid_ld_stale: load=%0b d_d=%h cnt=%0d rdy=%0b, want 0 0000 0 1", load, d_d, retire_cnt, in_ready);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1, 16'h0802, 16'(i), 0, 0);
      if (i == 14) begin
        n_checks++;
        if (retire_cnt4 !== 4'd15) begin
          n_errors++;
          $display("FAIL wrap_allones: cnt4=%0d, want 15", retire_cnt4);
        end
      end
    end
    n_checks++;
    if ({retire_cnt4, retire_cnt} !== {4'd0, 16'd16}) begin
      n_errors++;
      $display("FAIL wrap_zero: cnt4=%0d cnt16=%0d, want 0 16", retire_cnt4, retire_cnt);
    end
    cycle(0, 16'h0, 16'h0, 0, 0);
  endtask

  task automatic test_random();
    logic [15:0] inst, r;
    logic [85:0] exp_v, act_v;
    logic v, rv;
    int sel;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      r   = 16'($urandom);
      sel = $urandom_range(0, 4);
      case (sel)
        0: inst = {2'b00, r[13:5], 5'b00001};
        1: inst = {2'b00, r[13:5], 5'b00000};
        2: inst = {1'b1, r[14:0]};
        default: inst = r;
      endcase
      v  = ($urandom_range(0, 3) != 0);
      rv = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      cycle(v, inst, 16'($urandom), rv, 16'($urandom));
      exp_v = {!m_busy, m_load, m_wsel, m_da, m_dd, m_load, m_wsel[13:11],
               (f_is_ld(m_wsel) ? m_dd : m_da), 16'(m_cnt)};
      act_v = {in_ready, load, wsel, d_a, d_d, fwd_valid, fwd_reg, fwd_data, retire_cnt};
      n_checks++;
      if (act_v !== exp_v) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h, want %h (rdy,load,wsel,d_a,d_d,fv,freg,fdata,cnt)", n, act_v, exp_v);
      end
      n_checks++;
      if ({load4, retire_cnt4} !== {m_load, 4'(m_cnt)}) begin
        n_errors++;
        $display("FAIL random_w4[%0d]: load4=%0b cnt4=%0d, want %0b %0d", n, load4, retire_cnt4, m_load, 4'(m_cnt));
      end
    end
  endtask

  initial begin
    RSTN = 0;
    in_valid = 0; in_inst = 0; in_alu = 0; mem_rvalid = 0; mem_rdata = 0;
    model_reset();
    test_reset();
    test_alu_write();
    test_ld_wait();
    test_non_writers();
    test_back_to_back();
    test_reset_mid_ld();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
